// File: rtl/dlfloat_mul_seq.sv
// Sequential DLFloat multiplier: iterative shift-add significand product followed by a
// single normalise/round cycle, valid/ready on both sides, one operation in flight.
module dlfloat_mul_seq #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 9,
  parameter int BIAS  = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] flp_a,
  input  logic [EXP_W+MAN_W:0] flp_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [2:0]           flags
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;
  localparam int PW    = 2 * SIG_W;
  localparam int CNT_W = $clog2(SIG_W);
  localparam int EW    = EXP_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [MAN_W-1:0] MAN_ONES = '1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

  state_t r_state, w_next;

  logic             r_sign;
  logic [EXP_W-1:0] r_expA, r_expB;
  logic             r_isZero, r_isSpecial;
  logic [PW-1:0]    r_mcand, r_acc;
  logic [SIG_W-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_result;
  logic [2:0]       r_flags;

  logic [EXP_W-1:0] w_expAIn, w_expBIn;
  logic [MAN_W-1:0] w_fracAIn, w_fracBIn;
  logic             w_aZero, w_bZero, w_aSpecial, w_bSpecial;

  logic             w_msb, w_guard, w_sticky, w_roundUp;
  logic [MAN_W-1:0] w_frac, w_fracOut;
  logic [MAN_W:0]   w_fracRnd;
  logic [EW-1:0]    w_exp;
  logic             w_ovf, w_unf;
  logic [W-1:0]     w_res;
  logic [2:0]       w_flags;

  assign w_expAIn   = flp_a[W-2 -: EXP_W];
  assign w_expBIn   = flp_b[W-2 -: EXP_W];
  assign w_fracAIn  = flp_a[MAN_W-1:0];
  assign w_fracBIn  = flp_b[MAN_W-1:0];
  assign w_aZero    = (w_expAIn == '0);
  assign w_bZero    = (w_expBIn == '0);
  assign w_aSpecial = (w_expAIn == EXP_ONES) && (w_fracAIn == MAN_ONES);
  assign w_bSpecial = (w_expBIn == EXP_ONES) && (w_fracBIn == MAN_ONES);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_MUL;
      end
      S_MUL:  if (r_cnt == CNT_W'(MAN_W)) w_next = S_NORM;
      S_NORM: w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // MUL always runs the full count, even for zero/special operands, to keep latency fixed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign      <= 1'b0;
      r_expA      <= '0;
      r_expB      <= '0;
      r_isZero    <= 1'b0;
      r_isSpecial <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_flags     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_sign      <= flp_a[W-1] ^ flp_b[W-1];
          r_expA      <= w_expAIn;
          r_expB      <= w_expBIn;
          r_isZero    <= w_aZero | w_bZero;
          r_isSpecial <= w_aSpecial | w_bSpecial;
          r_mcand     <= {{SIG_W{1'b0}}, 1'b1, w_fracAIn};
          r_mplier    <= {1'b1, w_fracBIn};
          r_acc       <= '0;
          r_cnt       <= '0;
        end
        S_MUL: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mplier <= r_mplier >> 1;
          r_mcand  <= r_mcand << 1;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        S_NORM: begin
          r_result <= w_res;
          r_flags  <= w_flags;
        end
        default: ;
      endcase
    end
  end

  // Product is in [1,4): pick the fraction window by the MSB, then round to nearest even
  always_comb begin
    w_msb     = r_acc[PW-1];
    w_frac    = w_msb ? r_acc[PW-2 -: MAN_W] : r_acc[PW-3 -: MAN_W];
    w_guard   = w_msb ? r_acc[PW-2-MAN_W]    : r_acc[PW-3-MAN_W];
    w_sticky  = w_msb ? (|r_acc[PW-3-MAN_W:0]) : (|r_acc[PW-4-MAN_W:0]);
    w_roundUp = w_guard & (w_sticky | w_frac[0]);
    w_fracRnd = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_roundUp};
    w_fracOut = w_fracRnd[MAN_W-1:0];
    w_exp     = EW'(r_expA) + EW'(r_expB) - EW'(BIAS) + EW'(w_msb) + EW'(w_fracRnd[MAN_W]);
    w_ovf     = !w_exp[EW-1] &&
                ((w_exp > EW'(EXP_ONES)) ||
                 ((w_exp == EW'(EXP_ONES)) && (w_fracOut == MAN_ONES)));
    w_unf     = w_exp[EW-1] || (w_exp == '0);
  end

  // Priority: special beats zero (so zero x special is special), then overflow, then underflow
  always_comb begin
    w_res   = '0;
    w_flags = '0;
    if (r_isSpecial) begin
      w_res   = {1'b0, {(W-1){1'b1}}};
      w_flags = 3'b100;
    end else if (r_isZero) begin
      w_res   = '0;
      w_flags = 3'b000;
    end else if (w_ovf) begin
      w_res   = {1'b0, {(W-1){1'b1}}};
      w_flags = 3'b110;
    end else if (w_unf) begin
      w_res   = '0;
      w_flags = 3'b001;
    end else begin
      w_res   = {r_sign, w_exp[EXP_W-1:0], w_fracOut};
    end
  end

  assign result = r_result;
  assign flags  = r_flags;

endmodule

// File: tb/tb_dlfloat_mul_seq.sv
// Scoreboard bench for dlfloat_mul_seq: stimulus pushes reference results at accept,
// an output monitor pops and compares whenever the DUT presents a result.
module tb_dlfloat_mul_seq;

   localparam int EXP_W  = 6;
   localparam int MAN_W  = 9;
   localparam int BIAS   = 31;
   localparam int LAT    = MAN_W + 2;
   localparam int EXP_W2 = 8;
   localparam int MAN_W2 = 23;
   localparam int BIAS2  = 127;
   localparam int LAT2   = MAN_W2 + 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inValid = 1'b0;
   logic        inReady;
   logic [15:0] flpA = '0;
   logic [15:0] flpB = '0;
   logic        outValid;
   logic        outReady = 1'b1;
   logic [15:0] result;
   logic [2:0]  flags;

   logic        inValid2 = 1'b0;
   logic        inReady2;
   logic [31:0] flpA2 = '0;
   logic [31:0] flpB2 = '0;
   logic        outValid2;
   logic        outReady2 = 1'b1;
   logic [31:0] result2;
   logic [2:0]  flags2;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   logic holdReady = 1'b0;
   logic randReady = 1'b0;
   logic dirValid = 1'b0;
   logic [15:0] dirRes = '0;
   logic [2:0]  dirFl = '0;

   typedef struct {
      logic [15:0] res;
      logic [2:0]  fl;
      int          k;
   } exp_t;
   exp_t expQ[$];

   dlfloat_mul_seq dut (
      .clk(clk), .rst(rst),
      .in_valid(inValid), .in_ready(inReady),
      .flp_a(flpA), .flp_b(flpB),
      .out_valid(outValid), .out_ready(outReady),
      .result(result), .flags(flags)
   );

   dlfloat_mul_seq #(.EXP_W(EXP_W2), .MAN_W(MAN_W2), .BIAS(BIAS2)) dutWide (
      .clk(clk), .rst(rst),
      .in_valid(inValid2), .in_ready(inReady2),
      .flp_a(flpA2), .flp_b(flpB2),
      .out_valid(outValid2), .out_ready(outReady2),
      .result(result2), .flags(flags2)
   );

   always #5 clk = ~clk;

   // Free-running cycle count, read only on the falling edge
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Reference: exact integer product, rounding decided by comparing the dropped remainder to half an ulp
   function automatic void refMul(input int ew, input int mw, input int bias,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] res, output logic [2:0] fl);
      longint one = 1;
      longint emask, mmask, ea, eb, fa, fb, sgn, p, q, rem, half, e, frac, specCode;
      int shift;
      emask    = (one << ew) - 1;
      mmask    = (one << mw) - 1;
      specCode = (one << (ew + mw)) - 1;
      ea  = longint'(a >> mw) & emask;
      eb  = longint'(b >> mw) & emask;
      fa  = longint'(a) & mmask;
      fb  = longint'(b) & mmask;
      sgn = longint'((a >> (ew + mw)) ^ (b >> (ew + mw))) & 1;
      if ((ea == emask && fa == mmask) || (eb == emask && fb == mmask)) begin
         res = 64'(specCode); fl = 3'b100;
      end else if (ea == 0 || eb == 0) begin
         res = '0; fl = 3'b000;
      end else begin
         p = ((one << mw) + fa) * ((one << mw) + fb);
         e = ea + eb - bias;
         shift = mw;
         if (p >= (one << (2 * mw + 1))) begin
            shift = mw + 1;
            e = e + 1;
         end
         q    = p >> shift;
         rem  = p - (q << shift);
         half = one << (shift - 1);
         if (rem > half || (rem == half && q % 2 == 1)) q = q + 1;
         if (q == (one << (mw + 1))) begin
            q = q >> 1;
            e = e + 1;
         end
         frac = q - (one << mw);
         if (e > emask || (e == emask && frac == mmask)) begin
            res = 64'(specCode); fl = 3'b110;
         end else if (e <= 0) begin
            res = '0; fl = 3'b001;
         end else begin
            res = 64'((sgn << (ew + mw)) | (e << mw) | frac); fl = 3'b000;
         end
      end
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic failNow(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s: bound expired (cycle %0d)", name, cyc);
   endtask

   // Sink readiness: forced low, random, or always high
   initial forever begin
      @(posedge clk);
      #1;
      outReady = holdReady ? 1'b0 : (randReady ? ($urandom_range(0, 2) != 0) : 1'b1);
   end

   // Accept monitor: the reference result is queued the moment a handshake is seen
   initial begin
      exp_t e;
      logic [63:0] r;
      logic [2:0]  f;
      forever begin
         @(negedge clk);
         if (!rst && inValid && inReady) begin
            refMul(EXP_W, MAN_W, BIAS, 64'(flpA), 64'(flpB), r, f);
            e.res = dirValid ? dirRes : r[15:0];
            e.fl  = dirValid ? dirFl : f;
            e.k   = cyc + 1;
            expQ.push_back(e);
         end
      end
   end

   // Output monitor: compares every cycle a result is presented, pops on handshake
   initial begin
      logic prevValid = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            expQ.delete();
            prevValid = 1'b0;
         end else if (outValid) begin
            if (expQ.size() == 0) begin
               failNow("unexpected out_valid");
            end else begin
               if (!prevValid) checkOutput("latency", 64'(cyc - expQ[0].k), 64'(LAT));
               checkOutput("result", 64'(result), 64'(expQ[0].res));
               checkOutput("flags", 64'(flags), 64'(expQ[0].fl));
               checkOutput("in_ready while busy", 64'(inReady), 64'(0));
               if (outReady) void'(expQ.pop_front());
            end
            prevValid = !outReady;
         end else begin
            prevValid = 1'b0;
         end
      end
   end

   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
      int n = 0;
      @(posedge clk);
      #1;
      inValid = 1'b1;
      flpA = a;
      flpB = b;
      @(negedge clk);
      while (!inReady && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!inReady) failNow("accept wait");
      @(posedge clk);
      #1;
      inValid = 1'b0;
      flpA = 16'($urandom);
      flpB = 16'($urandom);
   endtask

   task automatic applyDirected(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] r, input logic [2:0] f);
      dirRes = r;
      dirFl = f;
      dirValid = 1'b1;
      applyStimulus(a, b);
      dirValid = 1'b0;
   endtask

   task automatic waitDrain();
      int n = 0;
      while ((expQ.size() != 0 || !inReady) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) failNow("drain wait");
   endtask

   function automatic logic [15:0] randOp16();
      int sel;
      logic [15:0] v;
      sel = $urandom_range(0, 9);
      v = 16'($urandom);
      if (sel == 0)      v[14:0] = 15'h7FFF;
      else if (sel == 1) v[14:9] = 6'd0;
      else if (sel < 7)  v[14:9] = 6'($urandom_range(18, 44));
      return v;
   endfunction

   task automatic runWide(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r, input logic [2:0] f);
      int n = 0;
      int k;
      @(posedge clk);
      #1;
      inValid2 = 1'b1;
      flpA2 = a;
      flpB2 = b;
      @(negedge clk);
      while (!inReady2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!inReady2) failNow("wide accept wait");
      k = cyc + 1;
      @(posedge clk);
      #1;
      inValid2 = 1'b0;
      n = 0;
      @(negedge clk);
      while (!outValid2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!outValid2) begin
         failNow("wide result wait");
      end else begin
         checkOutput("wide latency", 64'(cyc - k), 64'(LAT2));
         checkOutput("wide result", 64'(result2), 64'(r));
         checkOutput("wide flags", 64'(flags2), 64'(f));
      end
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [63:0] wr;
      logic [2:0]  wf;
      logic [31:0] wa, wb;
      int n;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset in_ready", 64'(inReady), 64'(1));
      checkOutput("reset out_valid", 64'(outValid), 64'(0));
      checkOutput("reset result", 64'(result), 64'(0));
      checkOutput("reset flags", 64'(flags), 64'(0));

      $display("[TB] directed vectors");
      applyDirected(16'h3F00, 16'h3F00, 16'h4040, 3'b000); waitDrain();
      applyDirected(16'h3F00, 16'hC000, 16'hC100, 3'b000); waitDrain();
      applyDirected(16'h3E01, 16'h3E01, 16'h3E02, 3'b000); waitDrain();
      applyDirected(16'h3E01, 16'h3F00, 16'h3F02, 3'b000); waitDrain();
      applyDirected(16'h0000, 16'hBF00, 16'h0000, 3'b000); waitDrain();
      applyDirected(16'h7FFF, 16'h3E00, 16'h7FFF, 3'b100); waitDrain();
      applyDirected(16'h0000, 16'h7FFF, 16'h7FFF, 3'b100); waitDrain();
      applyDirected(16'h7E00, 16'h7E00, 16'h7FFF, 3'b110); waitDrain();
      applyDirected(16'h0200, 16'h0200, 16'h0000, 3'b001); waitDrain();
      applyDirected(16'h7FFE, 16'h3E00, 16'h7FFE, 3'b000); waitDrain();
      applyDirected(16'h7FFE, 16'h3E01, 16'h7FFF, 3'b110); waitDrain();
      applyDirected(16'h0200, 16'h3E00, 16'h0200, 3'b000); waitDrain();
      applyDirected(16'h0200, 16'h3C00, 16'h0000, 3'b001); waitDrain();

      $display("[TB] backpressure");
      holdReady = 1'b1;
      applyDirected(16'h3F00, 16'h3F00, 16'h4040, 3'b000);
      n = 0;
      @(negedge clk);
      while (!outValid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!outValid) failNow("backpressure result wait");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         inValid = 1'b1;
         flpA = 16'h4000;
         flpB = 16'h4000;
         @(negedge clk);
         checkOutput("held in_ready", 64'(inReady), 64'(0));
         checkOutput("held out_valid", 64'(outValid), 64'(1));
      end
      holdReady = 1'b0;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("in_ready after handshake", 64'(inReady), 64'(1));
      checkOutput("out_valid after handshake", 64'(outValid), 64'(0));
      waitDrain();

      $display("[TB] reset during MUL");
      applyDirected(16'h3F00, 16'h3F00, 16'h4040, 3'b000);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post-reset out_valid", 64'(outValid), 64'(0));
      checkOutput("post-reset result", 64'(result), 64'(0));
      checkOutput("post-reset in_ready", 64'(inReady), 64'(1));
      applyDirected(16'h3E00, 16'h4000, 16'h4000, 3'b000);
      waitDrain();

      $display("[TB] random traffic");
      randReady = 1'b1;
      for (int i = 0; i < 150; i++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         applyStimulus(randOp16(), randOp16());
      end
      waitDrain();
      randReady = 1'b0;

      $display("[TB] wide configuration");
      runWide(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000);
      for (int i = 0; i < 10; i++) begin
         wa = $urandom;
         wb = $urandom;
         wa[30:23] = 8'($urandom_range(90, 165));
         wb[30:23] = 8'($urandom_range(90, 165));
         refMul(EXP_W2, MAN_W2, BIAS2, 64'(wa), 64'(wb), wr, wf);
         runWide(wa, wb, wr[31:0], wf);
      end

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
